sequence_player: RTL and testbench

Downstream consumer of the 100-entry, 2-bit game sequence produced by the sequence generator. It runs the Simon-style round loop:
- plays the first `round` entries of the sequence on four one-hot LEDs;
- checks the player's button presses against the same entries;
- advances the round on success and reports win or loss.

It sits between the sequence generator and the board I/O, which provides debounced buttons and drives the LEDs.

---
 rtl/simon_pkg.sv | 27 ++
 rtl/phase_timer.sv | 34 +++
 rtl/sequence_player.sv | 205 ++++++++++++++++++++
 tb/tb_sequence_player.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game datapath.
//   color_t         : 2-bit button / LED colour code
//   player_state_t  : sequence_player FSM states
//   SEQ_LEN_DEFAULT : default sequence depth and maximum round
//   color_onehot()  : colour code to one-hot LED vector
package simon_pkg;

    localparam int unsigned SEQ_LEN_DEFAULT = 100;
    localparam int unsigned LED_W           = 4;

    typedef logic [1:0] color_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHOW_ON  = 3'd1,
        ST_SHOW_OFF = 3'd2,
        ST_WAIT_BTN = 3'd3,
        ST_GAP      = 3'd4,
        ST_WIN      = 3'd5,
        ST_LOSE     = 3'd6
    } player_state_t;

    function automatic logic [LED_W-1:0] color_onehot(input color_t c);
        return LED_W'(1) << c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by all timed phases of the player.
//   clk, rst_n  : clock, async active-low reset
//   i_load      : load i_load_val (has priority over counting)
//   i_load_val  : phase length in cycles (>= 1)
//   i_en        : count down while the phase is running
//   o_done_c    : combinational; high in the last cycle of the phase
module phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done_c
);

    logic [W-1:0] r_count;

    // A phase loaded with N finishes on the N-th edge after the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    // A cleared counter also reads as done so nothing can stall on it.
    assign o_done_c = (r_count <= W'(1));

endmodule

// File: rtl/sequence_player.sv
// Simon round loop: plays the first `round` sequence entries on one-hot
// LEDs, checks the player's presses against them and reports win/lose.
//   clk, rst_n     : clock, async active-low reset
//   game_sequence  : SEQ_LEN colour entries, stable while busy
//   start          : one-cycle pulse, begins a game from IDLE
//   btn_valid      : one-cycle pulse per debounced press
//   btn_color      : colour of the press
//   led            : one-hot colour while a step is lit, else 0
//   round          : current round 1..SEQ_LEN, 0 in IDLE
//   busy           : high outside IDLE
//   win / lose     : one-cycle result pulses
// Build option: define SEQUENCE_PLAYER_TIMEOUT_EN to lose after
// TIMEOUT_CYCLES idle cycles in the input phase.
module sequence_player
    import simon_pkg::*;
#(
    parameter int unsigned SEQ_LEN        = SEQ_LEN_DEFAULT,
    parameter int unsigned ON_CYCLES      = 25_000_000,
    parameter int unsigned OFF_CYCLES     = 12_500_000,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  color_t [SEQ_LEN-1:0]         game_sequence,
    input  logic                         start,
    input  logic                         btn_valid,
    input  color_t                       btn_color,
    output logic [LED_W-1:0]             led,
    output logic [$clog2(SEQ_LEN+1)-1:0] round,
    output logic                         busy,
    output logic                         win,
    output logic                         lose
);

    localparam int unsigned IDX_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int unsigned RND_W   = $clog2(SEQ_LEN + 1);
    localparam int unsigned MAX_PH  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_PH > TIMEOUT_CYCLES) ? MAX_PH : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

    player_state_t    r_state,  w_state_nxt;
    logic [IDX_W-1:0] r_idx,    w_idx_nxt;
    logic [RND_W-1:0] r_round,  w_round_nxt;
    logic [LED_W-1:0] r_led,    w_led_nxt;
    logic             r_busy,   w_busy_nxt;
    logic             r_win,    w_win_nxt;
    logic             r_lose,   w_lose_nxt;

    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_en;
    logic             w_tmr_done;
    logic             w_last;

    phase_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_done_c   (w_tmr_done)
    );

    // Current step is the last one of this round.
    assign w_last = (RND_W'(r_idx) == (r_round - RND_W'(1)));

    // State, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_round <= '0;
            r_led   <= '0;
            r_busy  <= 1'b0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_round <= w_round_nxt;
            r_led   <= w_led_nxt;
            r_busy  <= w_busy_nxt;
            r_win   <= w_win_nxt;
            r_lose  <= w_lose_nxt;
        end
    end

    // Next-state, timer control and next output values.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_round_nxt = r_round;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_tmr_en    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // start has priority; presses are never looked at here
                if (start) begin
                    w_round_nxt = RND_W'(1);
                    w_idx_nxt   = '0;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TMR_W'(ON_CYCLES);
                    w_state_nxt = ST_SHOW_ON;
                end
            end

            ST_SHOW_ON: begin
                w_tmr_en = 1'b1;
                if (w_tmr_done) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TMR_W'(OFF_CYCLES);
                    w_state_nxt = ST_SHOW_OFF;
                end
            end

            ST_SHOW_OFF: begin
                w_tmr_en = 1'b1;
                if (w_tmr_done) begin
                    if (w_last) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_WAIT_BTN;
`ifdef SEQUENCE_PLAYER_TIMEOUT_EN
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TMR_W'(TIMEOUT_CYCLES);
`endif
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TMR_W'(ON_CYCLES);
                        w_state_nxt = ST_SHOW_ON;
                    end
                end
            end

            ST_WAIT_BTN: begin
`ifdef SEQUENCE_PLAYER_TIMEOUT_EN
                w_tmr_en = 1'b1;
`endif
                if (btn_valid) begin
                    if (btn_color != game_sequence[r_idx]) begin
                        w_state_nxt = ST_LOSE;
                    end else if (!w_last) begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
`ifdef SEQUENCE_PLAYER_TIMEOUT_EN
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TMR_W'(TIMEOUT_CYCLES);
`endif
                    end else if (r_round == RND_W'(SEQ_LEN)) begin
                        w_state_nxt = ST_WIN;
                    end else begin
                        w_round_nxt = r_round + RND_W'(1);
                        w_idx_nxt   = '0;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TMR_W'(OFF_CYCLES);
                        w_state_nxt = ST_GAP;
                    end
                end
`ifdef SEQUENCE_PLAYER_TIMEOUT_EN
                else if (w_tmr_done) begin
                    w_state_nxt = ST_LOSE;
                end
`endif
            end

            ST_GAP: begin
                w_tmr_en = 1'b1;
                if (w_tmr_done) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TMR_W'(ON_CYCLES);
                    w_state_nxt = ST_SHOW_ON;
                end
            end

            ST_WIN, ST_LOSE: begin
                w_round_nxt = '0;
                w_idx_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_round_nxt = '0;
                w_idx_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they line up with it.
        w_led_nxt  = (w_state_nxt == ST_SHOW_ON) ? color_onehot(game_sequence[w_idx_nxt])
                                                 : '0;
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_win_nxt  = (w_state_nxt == ST_WIN);
        w_lose_nxt = (w_state_nxt == ST_LOSE);
    end

    assign led   = r_led;
    assign round = r_round;
    assign busy  = r_busy;
    assign win   = r_win;
    assign lose  = r_lose;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with SEQ_LEN=3, ON=4, OFF=2, TIMEOUT=20
// and sequence 2,0,3.
module tb_sequence_player;
    import simon_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    color_t [2:0]        seq;
    logic                start;
    logic                btn_valid;
    color_t              btn_color;
    logic [3:0]          led;
    logic [1:0]          round;
    logic                busy;
    logic                win;
    logic                lose;

    int n_checks = 0;
    int n_errors = 0;

    sequence_player #(
        .SEQ_LEN        (3),
        .ON_CYCLES      (4),
        .OFF_CYCLES     (2),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .game_sequence (seq),
        .start         (start),
        .btn_valid     (btn_valid),
        .btn_color     (btn_color),
        .led           (led),
        .round         (round),
        .busy          (busy),
        .win           (win),
        .lose          (lose)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_led(input string tag, input logic [3:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, 32'(led), 32'(exp));
            tick();
        end
    endtask

    // One played step: lit for ON cycles, dark for OFF cycles.
    task automatic play_step(input logic [3:0] exp);
        expect_led("led_on", exp, 4);
        expect_led("led_off", 4'b0000, 2);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press(input color_t c);
        btn_valid = 1'b1;
        btn_color = c;
        tick();
        btn_valid = 1'b0;
        btn_color = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_lose;
        seq[0] = 2'd2;
        seq[1] = 2'd0;
        seq[2] = 2'd3;
        rst_n = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_color = 2'd0;
        tick(); tick();
        check("rst_led",   32'(led),   32'd0);
        check("rst_round", 32'(round), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_win",   32'(win),   32'd0);
        check("rst_lose",  32'(lose),  32'd0);
        rst_n = 1'b1;
        tick();

        // Round 1 correct, round 2 wrong press
        pulse_start();
        check("start_busy",  32'(busy),  32'd1);
        check("start_round", 32'(round), 32'd1);
        play_step(4'b0100);
        press(2'd2);
        check("r1_round", 32'(round), 32'd2);
        check("r1_lose",  32'(lose),  32'd0);
        expect_led("gap", 4'b0000, 2);
        play_step(4'b0100);
        play_step(4'b0001);
        press(2'd2);
        check("r2a_round", 32'(round), 32'd2);
        check("r2a_lose",  32'(lose),  32'd0);
        press(2'd1);
        check("wrong_lose", 32'(lose), 32'd1);
        check("wrong_busy", 32'(busy), 32'd1);
        tick();
        check("after_lose_lose",  32'(lose),  32'd0);
        check("after_lose_busy",  32'(busy),  32'd0);
        check("after_lose_round", 32'(round), 32'd0);
        tick();

        // Full win, with ignored inputs during SHOW_ON
        pulse_start();
        check("w_led0", 32'(led), 32'b0100);
        start = 1'b1; btn_valid = 1'b1; btn_color = 2'd1;
        tick();
        start = 1'b0; btn_valid = 1'b0; btn_color = 2'd0;
        expect_led("ign_led", 4'b0100, 3);
        check("ign_round", 32'(round), 32'd1);
        expect_led("ign_off", 4'b0000, 2);
        press(2'd2);
        check("w_r2", 32'(round), 32'd2);
        expect_led("gap", 4'b0000, 2);
        play_step(4'b0100);
        play_step(4'b0001);
        press(2'd2);
        press(2'd0);
        check("w_r3", 32'(round), 32'd3);
        expect_led("gap", 4'b0000, 2);
        play_step(4'b0100);
        play_step(4'b0001);
        play_step(4'b1000);
        press(2'd2);
        press(2'd0);
        check("w_pre_win", 32'(win), 32'd0);
        press(2'd3);
        check("win_pulse", 32'(win),   32'd1);
        check("win_round", 32'(round), 32'd3);
        check("win_busy",  32'(busy),  32'd1);
        tick();
        check("win_end",       32'(win),   32'd0);
        check("win_end_busy",  32'(busy),  32'd0);
        check("win_end_round", 32'(round), 32'd0);
        tick();

`ifdef SEQUENCE_PLAYER_TIMEOUT_EN
        // Plain timeout in round 1
        pulse_start();
        play_step(4'b0100);
        saw_lose = 1'b0;
        for (int i = 0; i < 19; i++) begin
            saw_lose |= lose;
            tick();
        end
        check("to_early", 32'(saw_lose | lose), 32'd0);
        tick();
        check("to_lose", 32'(lose), 32'd1);
        tick();
        check("to_idle", 32'(busy), 32'd0);

        // Press at cycle 15 reloads the timeout
        pulse_start();
        play_step(4'b0100);
        press(2'd2);
        expect_led("gap", 4'b0000, 2);
        play_step(4'b0100);
        play_step(4'b0001);
        saw_lose = 1'b0;
        for (int i = 0; i < 14; i++) begin
            saw_lose |= lose;
            tick();
        end
        press(2'd2);
        for (int i = 0; i < 19; i++) begin
            saw_lose |= lose;
            tick();
        end
        check("rl_early", 32'(saw_lose | lose), 32'd0);
        check("rl_busy",  32'(busy), 32'd1);
        tick();
        check("rl_lose", 32'(lose), 32'd1);
        tick();
`else
        // No timeout: WAIT_BTN holds indefinitely
        pulse_start();
        play_step(4'b0100);
        saw_lose = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            saw_lose |= lose;
            tick();
        end
        check("nto_lose", 32'(saw_lose), 32'd0);
        check("nto_busy", 32'(busy), 32'd1);
        press(2'd3);
        check("nto_wrong", 32'(lose), 32'd1);
        tick();
`endif

        // Asynchronous reset during SHOW_ON
        tick();
        pulse_start();
        check("pre_rst_led", 32'(led), 32'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_led",   32'(led),   32'd0);
        check("arst_busy",  32'(busy),  32'd0);
        check("arst_round", 32'(round), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        check("rs_round", 32'(round), 32'd1);
        play_step(4'b0100);
        press(2'd2);
        check("rs_r2", 32'(round), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
